// File: rtl/move_cmd_pkg.sv
// move_cmd_pkg: shared state encoding, opcodes and default heading threshold for move_cmd_proc.
package move_cmd_pkg;
    typedef enum logic [2:0] {IDLE, CAL, HEAD, RAMP, DECEL, DONE} state_t;
    localparam logic [3:0] OP_CAL      = 4'h0;
    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_MOVE_FAN = 4'h3;
    localparam logic [3:0] OP_TOUR     = 4'h4;
    localparam logic [3:0] OP_STOP     = 4'h5;
    localparam logic [11:0] ERR_THRESH_DEF = 12'h02C;
endpackage

// File: rtl/move_cmd_proc_speed_ramp.sv
// speed_ramp: forward-speed register with saturating ramp-up and floor-at-zero ramp-down.
module speed_ramp #(
    parameter int FRWRD_W = 10,
    parameter logic [FRWRD_W-1:0] MAX_SPD = 10'h300,
    parameter logic [FRWRD_W-1:0] INC = 10'h020,
    parameter int DEC_SHIFT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic [FRWRD_W-1:0] frwrd_o
);
    localparam logic [FRWRD_W:0] STEP = {1'b0, INC} << DEC_SHIFT;
    logic [FRWRD_W-1:0] frwrd_q, frwrd_d;
    logic [FRWRD_W:0] sum;
    always_comb begin
        sum = {1'b0, frwrd_q} + {1'b0, INC};
        frwrd_d = clr_i ? '0 :
                  inc_i ? (sum > {1'b0, MAX_SPD} ? MAX_SPD : sum[FRWRD_W-1:0]) :
                  dec_i ? ({1'b0, frwrd_q} > STEP ? frwrd_q - STEP[FRWRD_W-1:0] : '0) :
                  frwrd_q;
    end
    always_ff @(posedge clk)
        frwrd_q <= !rst_n ? '0 : frwrd_d;
    assign frwrd_o = frwrd_q;
endmodule

// File: rtl/move_cmd_proc.sv
// move_cmd_proc: decodes robot commands, steers heading error with guard-rail nudge and sequences speed ramps.
module move_cmd_proc import move_cmd_pkg::*; #(
    parameter int FAST_SIM = 1,
    parameter int FRWRD_W = 10,
    parameter logic [FRWRD_W-1:0] MAX_SPD = 10'h300,
    parameter logic [FRWRD_W-1:0] INC = 10'h020,
    parameter int DEC_SHIFT = 1,
    parameter logic [11:0] ERR_THRESH = ERR_THRESH_DEF,
    parameter logic [11:0] NUDGE_FAST = 12'h1FF,
    parameter logic [11:0] NUDGE_SLOW = 12'h05F
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [15:0] cmd,
    input  logic cmd_rdy,
    input  logic cal_done,
    input  logic heading_rdy,
    input  logic [11:0] heading,
    input  logic lftIR,
    input  logic cntrIR,
    input  logic rghtIR,
    output logic [11:0] error,
    output logic [FRWRD_W-1:0] frwrd,
    output logic clr_cmd_rdy,
    output logic send_resp,
    output logic strt_cal,
    output logic moving,
    output logic tour_go,
    output logic fanfare_go
);
    localparam logic [11:0] NUDGE = FAST_SIM != 0 ? NUDGE_FAST : NUDGE_SLOW;
    state_t state_q;
    logic [11:0] desired_q, nudge;
    logic [3:0] n_q, op;
    logic [4:0] cnt_q;
    logic [12:0] err_x, err_abs;
    logic fan_q, cntr_q, strt_cal_q, send_resp_q, tour_go_q, fanfare_go_q, moving_q;
    logic stop_abort, aligned, cntr_rise;
    always_comb begin
        op = cmd[15:12];
        nudge = lftIR ? NUDGE : rghtIR ? -NUDGE : 12'h000;
        error = heading - desired_q + nudge;
        err_x = {error[11], error};
        err_abs = err_x[12] ? -err_x : err_x;
        aligned = err_abs < {1'b0, ERR_THRESH};
        stop_abort = cmd_rdy && op == OP_STOP && (state_q == HEAD || state_q == RAMP);
        clr_cmd_rdy = (cmd_rdy && state_q == IDLE) || stop_abort;
        cntr_rise = cntrIR && !cntr_q;
    end
    speed_ramp #(.FRWRD_W(FRWRD_W), .MAX_SPD(MAX_SPD), .INC(INC), .DEC_SHIFT(DEC_SHIFT)) u_ramp (
        .clk(clk),
        .rst_n(rst_n),
        .clr_i(state_q == HEAD),
        .inc_i(state_q == RAMP && heading_rdy),
        .dec_i(state_q == DECEL && heading_rdy),
        .frwrd_o(frwrd)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            desired_q <= '0;
            n_q <= '0;
            cnt_q <= '0;
            fan_q <= 1'b0;
            cntr_q <= 1'b0;
            strt_cal_q <= 1'b0;
            send_resp_q <= 1'b0;
            tour_go_q <= 1'b0;
            fanfare_go_q <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            strt_cal_q <= 1'b0;
            send_resp_q <= 1'b0;
            tour_go_q <= 1'b0;
            fanfare_go_q <= 1'b0;
            cntr_q <= cntrIR;
            if (cntr_rise && (state_q == RAMP || state_q == DECEL)) cnt_q <= cnt_q + 5'd1;
            case (state_q)
                IDLE: if (cmd_rdy) begin
                    if (op == OP_CAL) begin
                        strt_cal_q <= 1'b1;
                        state_q <= CAL;
                    end else if (op == OP_MOVE || op == OP_MOVE_FAN) begin
                        desired_q <= cmd[11:4] == 8'h00 ? 12'h000 : {cmd[11:4], 4'hF};
                        n_q <= cmd[3:0];
                        fan_q <= cmd[12];
                        cnt_q <= '0;
                        moving_q <= 1'b1;
                        state_q <= HEAD;
                    end else if (op == OP_TOUR) tour_go_q <= 1'b1;
                    else if (op == OP_STOP) send_resp_q <= 1'b1;
                end
                CAL: if (cal_done) begin
                    send_resp_q <= 1'b1;
                    state_q <= IDLE;
                end
                HEAD, RAMP: if (stop_abort) begin
                    fan_q <= 1'b0;
                    state_q <= DECEL;
                end else if (state_q == HEAD) begin
                    if (aligned) begin
                        moving_q <= n_q != 4'h0;
                        state_q <= n_q == 4'h0 ? DONE : RAMP;
                    end
                end else if (cnt_q == {n_q, 1'b0}) state_q <= DECEL;
                DECEL: if (frwrd == '0) begin
                    moving_q <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    send_resp_q <= 1'b1;
                    fanfare_go_q <= fan_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign strt_cal = strt_cal_q;
    assign send_resp = send_resp_q;
    assign tour_go = tour_go_q;
    assign fanfare_go = fanfare_go_q;
    assign moving = moving_q;
endmodule

// File: tb/tb_move_cmd_proc.sv
// tb_move_cmd_proc: directed vectors with hand-computed expectations for move_cmd_proc.
module tb_move_cmd_proc;
    logic clk = 1'b0;
    logic rst_n, cmd_rdy, cal_done, heading_rdy, lftIR, cntrIR, rghtIR;
    logic [15:0] cmd;
    logic [11:0] heading, error;
    logic [9:0] frwrd;
    logic clr_cmd_rdy, send_resp, strt_cal, moving, tour_go, fanfare_go;
    int n_vec = 0, n_err = 0;
    int n_resp = 0, n_fan = 0, n_both = 0, n_cal = 0, n_tour = 0, n_mv = 0;
    int b_resp, b_fan, b_both, b_cal, b_tour, b_mv;
    bit acked;

    move_cmd_proc dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .cal_done(cal_done),
        .heading_rdy(heading_rdy), .heading(heading), .lftIR(lftIR), .cntrIR(cntrIR),
        .rghtIR(rghtIR), .error(error), .frwrd(frwrd), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .strt_cal(strt_cal), .moving(moving), .tour_go(tour_go),
        .fanfare_go(fanfare_go)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (send_resp) n_resp++;
        if (fanfare_go) n_fan++;
        if (send_resp && fanfare_go) n_both++;
        if (strt_cal) n_cal++;
        if (tour_go) n_tour++;
        if (moving) n_mv++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_resp = n_resp; b_fan = n_fan; b_both = n_both;
        b_cal = n_cal; b_tour = n_tour; b_mv = n_mv;
    endtask

    task automatic send(input logic [15:0] c, input int lim, output bit ok);
        cmd = c;
        cmd_rdy = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            #1;
            if (clr_cmd_rdy) ok = 1'b1;
            @(negedge clk);
        end
        cmd_rdy = 1'b0;
    endtask

    task automatic hrdy(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) heading_rdy = 1'b1;
            @(negedge clk) heading_rdy = 1'b0;
        end
    endtask

    task automatic line();
        @(negedge clk) cntrIR = 1'b1;
        repeat (2) @(negedge clk);
        cntrIR = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 100 && n_resp == b_resp; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cmd = '0; cmd_rdy = 0; cal_done = 0; heading_rdy = 0;
        heading = '0; lftIR = 0; cntrIR = 0; rghtIR = 0;
        repeat (3) @(negedge clk);
        chk("rst_frwrd", frwrd, 0);
        chk("rst_moving", moving, 0);
        chk("rst_pulses", {send_resp, strt_cal, tour_go, fanfare_go, clr_cmd_rdy}, 0);
        chk("rst_error", error, 0);
        rst_n = 1'b1;
        @(negedge clk);

        snap();
        send(16'h0000, 5, acked);
        chk("cal_ack", acked, 1);
        repeat (1000) @(negedge clk);
        cal_done = 1'b1;
        @(negedge clk) cal_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("cal_strt", n_cal - b_cal, 1);
        chk("cal_resp", n_resp - b_resp, 1);
        chk("cal_moving", n_mv - b_mv, 0);

        snap();
        heading = 12'h100;
        send(16'h2001, 5, acked);
        chk("mv_ack", acked, 1);
        chk("mv_moving", moving, 1);
        hrdy(3);
        line();
        chk("head_hold", frwrd, 0);
        heading = 12'h000;
        repeat (2) @(negedge clk);
        hrdy(10);
        chk("ramp10", frwrd, 10'h140);
        hrdy(14);
        chk("ramp24", frwrd, 10'h300);
        hrdy(2);
        chk("ramp_sat", frwrd, 10'h300);
        lftIR = 1'b1; #1;
        chk("nudge_l", error, 12'h1FF);
        lftIR = 1'b0; rghtIR = 1'b1; #1;
        chk("nudge_r", error, 12'hE01);
        lftIR = 1'b1; #1;
        chk("nudge_both", error, 12'h1FF);
        lftIR = 1'b0; rghtIR = 1'b0;
        line();
        hrdy(3);
        chk("line1_hold", frwrd, 10'h300);
        line();
        hrdy(1);
        chk("decel1", frwrd, 10'h2C0);
        hrdy(1);
        chk("decel2", frwrd, 10'h280);
        hrdy(10);
        chk("decel_zero", frwrd, 0);
        wait_resp();
        chk("mv_resp", n_resp - b_resp, 1);
        chk("mv_nofan", n_fan - b_fan, 0);
        chk("mv_done_moving", moving, 0);

        snap();
        send(16'h3002, 5, acked);
        chk("fan_ack", acked, 1);
        repeat (2) @(negedge clk);
        hrdy(24);
        chk("fan_ramp", frwrd, 10'h300);
        line(); line(); line();
        hrdy(2);
        chk("fan_line3", frwrd, 10'h300);
        line();
        hrdy(12);
        chk("fan_zero", frwrd, 0);
        wait_resp();
        chk("fan_resp", n_resp - b_resp, 1);
        chk("fan_both", n_both - b_both, 1);

        snap();
        send(16'h2400, 5, acked);
        chk("n0_ack", acked, 1);
        chk("n0_error", error, 12'hBF1);
        send(16'h4000, 5, acked);
        chk("busy_noack", acked, 0);
        heading = 12'h40F;
        wait_resp();
        chk("n0_resp", n_resp - b_resp, 1);
        chk("n0_frwrd", frwrd, 0);
        chk("n0_notour", n_tour - b_tour, 0);
        heading = 12'h000;

        snap();
        send(16'h3001, 5, acked);
        repeat (2) @(negedge clk);
        hrdy(24);
        chk("stop_pre", frwrd, 10'h300);
        send(16'h5000, 1, acked);
        chk("stop_ack", acked, 1);
        hrdy(11);
        chk("stop_decel", frwrd, 10'h040);
        hrdy(1);
        chk("stop_zero", frwrd, 0);
        wait_resp();
        repeat (5) @(negedge clk);
        chk("stop_resp", n_resp - b_resp, 1);
        chk("stop_nofan", n_fan - b_fan, 0);

        snap();
        send(16'h4000, 5, acked);
        repeat (2) @(negedge clk);
        chk("tour_go", n_tour - b_tour, 1);
        send(16'hF000, 5, acked);
        repeat (2) @(negedge clk);
        chk("unk_ack", acked, 1);
        chk("unk_noresp", n_resp - b_resp, 0);
        send(16'h5000, 5, acked);
        repeat (2) @(negedge clk);
        chk("idle_stop_resp", n_resp - b_resp, 1);

        send(16'h2001, 5, acked);
        repeat (2) @(negedge clk);
        hrdy(5);
        chk("rst_pre", frwrd, 10'h0A0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_frwrd", frwrd, 0);
        chk("rst_mid_moving", moving, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
